// File: rtl/wb_arb_pkg.sv
// Shared constants for the two-master Wishbone memory arbiter.
package wb_arb_pkg;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_GNT_M0 = 2'd1;
    localparam logic [1:0] ARB_GNT_M1 = 2'd2;

    localparam logic M_CORE = 1'b0;
    localparam logic M_UART = 1'b1;

    // Grant state that corresponds to a master index.
    function automatic logic [1:0] gnt_state(input logic m);
        return (m == M_UART) ? ARB_GNT_M1 : ARB_GNT_M0;
    endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Wait-cycle counter for a granted transfer; hit fires on the last allowed wait cycle.
module arb_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_r;

    // hit is combinational so the abort lands in the same cycle as the final wait.
    assign hit = inc & (cnt_r == LAST_WAIT);

    // Counter register: clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone arbiter sharing one single-port memory between the core and the UART bridge.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic                  m0_stall_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  m1_stall_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i
);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic       last_r;
    logic       gnt0_s;
    logic       gnt1_s;
    logic       hit_s;
    logic       clr_s;
    logic       inc_s;

    assign gnt0_s = (state_r == ARB_GNT_M0);
    assign gnt1_s = (state_r == ARB_GNT_M1);
    assign inc_s  = ((gnt0_s & m0_stb_i) | (gnt1_s & m1_stb_i)) & ~s_ack_i;
    assign clr_s  = s_ack_i | (state_nxt_s != state_r);

    arb_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk(clk),
        .rst(rst),
        .clr(clr_s),
        .inc(inc_s),
        .hit(hit_s)
    );

    // Next-state logic: round-robin on ties, direct handoff when the other master waits.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt_s = gnt_state(~last_r);
                end else if (m0_cyc_i) begin
                    state_nxt_s = ARB_GNT_M0;
                end else if (m1_cyc_i) begin
                    state_nxt_s = ARB_GNT_M1;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_GNT_M0: begin
                if (hit_s) begin
                    state_nxt_s = ARB_IDLE;
                end else if (m0_cyc_i) begin
                    state_nxt_s = ARB_GNT_M0;
                end else if (m1_cyc_i) begin
                    state_nxt_s = ARB_GNT_M1;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_GNT_M1: begin
                if (hit_s) begin
                    state_nxt_s = ARB_IDLE;
                end else if (m1_cyc_i) begin
                    state_nxt_s = ARB_GNT_M1;
                end else if (m0_cyc_i) begin
                    state_nxt_s = ARB_GNT_M0;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // State register; reset leaves last pointing at the UART so the core wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ARB_IDLE;
            last_r  <= M_UART;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s == ARB_GNT_M0) begin
                last_r <= M_CORE;
            end else if (state_nxt_s == ARB_GNT_M1) begin
                last_r <= M_UART;
            end else begin
                last_r <= last_r;
            end
        end
    end

    // Request and response muxing; a timeout hit drops cyc/stb toward memory for that cycle.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = {ADDR_WIDTH{1'b0}};
        s_dat_o  = {DATA_WIDTH{1'b0}};
        m0_dat_o = {DATA_WIDTH{1'b0}};
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = {DATA_WIDTH{1'b0}};
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        if (gnt0_s) begin
            s_cyc_o  = m0_cyc_i & ~hit_s;
            s_stb_o  = m0_stb_i & ~hit_s;
            s_we_o   = m0_we_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = hit_s;
        end else if (gnt1_s) begin
            s_cyc_o  = m1_cyc_i & ~hit_s;
            s_stb_o  = m1_stb_i & ~hit_s;
            s_we_o   = m1_we_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = hit_s;
        end else begin
            s_cyc_o = 1'b0;
        end
    end

    // Stall is held low while in reset so every output is quiet during reset.
    assign m0_stall_o = rst & m0_cyc_i & ~gnt0_s;
    assign m1_stall_o = rst & m1_cyc_i & ~gnt1_s;

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Two-master Wishbone arbiter that shares one single-port memory (data or instruction `mem`) between the core and the `uart_wbs_bridge`. It sits directly upstream of a `mem` instance and replaces the static `select_mem` muxing. Grants are round-robin and held for a whole `cyc` cycle. The block stalls whichever master is not granted and aborts hung transfers with an error pulse.

## Interface
- `DATA_WIDTH`, 32, data bus width
- `ADDR_WIDTH`, 10, word address width forwarded to `mem`
- `TIMEOUT`, 255, cycles without `s_ack_i` before a granted transfer is aborted (1..65535)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  core master controls
- `m0_adr_i`  in  ADDR_WIDTH  core address
- `m0_dat_i`  in  DATA_WIDTH  core write data
- `m0_dat_o`  out  DATA_WIDTH  read data to core
- `m0_ack_o`, `m0_err_o`, `m0_stall_o`  out  1 each  core ack, timeout error, stall
- `m1_*`  same set as `m0_*`  UART bridge master
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to memory
- `s_adr_o`  out  ADDR_WIDTH  to memory
- `s_dat_o`  out  DATA_WIDTH  write data to memory
- `s_dat_i`  in  DATA_WIDTH  read data from memory
- `s_ack_i`  in  1  memory acknowledge

## Operation
- FSM states: IDLE, GNT_M0, GNT_M1. There is also a 1-bit `last` register holding the most recently granted master.
- IDLE, requests:
  - Only one `mX_cyc_i` high → go to GNT_MX.
  - Both high → grant the master that is not `last`.
  - Neither high → stay in IDLE.
- GNT_MX:
  - Hold while `mX_cyc_i` stays high.
  - On `mX_cyc_i` low, if the other master's `cyc` is high → go directly to GNT_other (no IDLE bubble); otherwise → IDLE.
  - `last` updates on every entry into a GNT state.
- Slave-side routing:
  - `s_*` outputs are combinational copies of the granted master's inputs.
  - In IDLE all `s_*` outputs are 0.
- Response routing:
  - `s_ack_i` and `s_dat_i` are routed only to the granted master.
  - The non-granted master sees `ack`=0 and `dat`=0.
- `mX_stall_o` = `mX_cyc_i` & !(state==GNT_MX).
- Timeout counter:
  - Width is clog2(TIMEOUT+1).
  - Clears on entry to a GNT state and on every `s_ack_i`.
  - Increments while granted with `stb` high and `s_ack_i` low.
  - On reaching TIMEOUT: `mX_err_o` pulses for 1 cycle, `s_cyc_o` and `s_stb_o` are forced low that cycle, and the FSM goes to IDLE with `last`=X. The master must drop `cyc`; a re-request is re-arbitrated.
- Granted master drops `cyc` with no ack: release is clean and the counter clears. An `s_ack_i` arriving in that same cycle is still forwarded to that master.
- No write-data buffering; the block is combinational on the data path and adds no storage.

## Timing
- Reset values: state=IDLE, `last`=1 (so m0 wins the first tie), counter=0. All outputs are 0, and `mX_stall_o`=0 until `cyc` is seen.
- Arbitration latency: request at cycle N → grant registered at N+1 → `s_stb_o` high at N+1.
  - `mX_stall_o` is high during cycle N.
- With `mem` 1-cycle ack, a single access costs 3 cycles from `cyc` to ack, measured as N, N+1, ack at N+2.
- Handoff GNT_M0→GNT_M1 takes exactly 1 cycle after m0 drops `cyc`.
- Reset mid-transfer: the FSM goes to IDLE immediately (asynchronously) and all outputs go to 0. No err pulse.

## Structure
- Package `wb_arb_pkg`:
  - State localparams ARB_IDLE=2'd0, ARB_GNT_M0=2'd1, ARB_GNT_M1=2'd2.
  - Master index constants M_CORE=1'b0, M_UART=1'b1.
- Sub-module `arb_timeout_ctr`: the counter with `clr`, `inc` and a `hit` output.
- The FSM and the muxes stay in `wb_mem_arbiter`.

## Test plan
- Reset release, then m0 read of addr 0x004 (memory holds 0xDEADBEEF) → `s_stb_o` high at N+1, `m0_ack_o` with `m0_dat_o`=0xDEADBEEF, `m1_stall_o`=0 throughout.
- m0 and m1 raise `cyc` in the same cycle, both twice in a row → grant order m0, m1, m0, m1, and each loser's stall is high until its grant.
- m1 writes 0x00000013 to 0x010 while m0 holds `cyc` → m1 stalled until m0 drops `cyc`, handoff in 1 cycle, memory word 0x010 = 0x00000013.
- TIMEOUT=4, memory `ack` tied low, m0 `stb` held → `m0_err_o` pulse on the 4th wait cycle, FSM in IDLE next cycle, `s_cyc_o`=0.
- `rst` asserted mid-m1 transfer → all outputs 0 within the same cycle; after release a tie goes to m0.
- Granted m1 drops `cyc` in the same cycle `s_ack_i` arrives, m0 waiting → `m1_ack_o`=1 that cycle, m0 granted the next cycle.
